// File: rtl/line_render_scheduler_if.sv
// Composer/renderer handshake bundle for line_render_scheduler.
// Optional RENDER_STATS_EN adds max_busy_cycles to the bundle.
interface line_render_scheduler_if;
  logic       line_render_start;
  logic [8:0] line_idx;
  logic       sprites_enabled;
  logic       layer0_enabled;
  logic       layer1_enabled;
  logic       sprite_done;
  logic       layer0_done;
  logic       layer1_done;
  logic       err_clear;
  logic [8:0] render_line_idx;
  logic       sprite_start;
  logic       layer0_start;
  logic       layer1_start;
  logic       render_abort;
  logic [1:0] vram_owner;
  logic       lb_wr_bank;
  logic       lb_rd_bank;
  logic       busy;
  logic       overrun;
  logic       timeout_err;
  logic [7:0] overrun_count;
`ifdef RENDER_STATS_EN
  logic [15:0] max_busy_cycles;
`endif

  modport master (
    output line_render_start, line_idx, sprites_enabled, layer0_enabled, layer1_enabled,
           sprite_done, layer0_done, layer1_done, err_clear,
    input  render_line_idx, sprite_start, layer0_start, layer1_start, render_abort,
           vram_owner, lb_wr_bank, lb_rd_bank, busy, overrun, timeout_err, overrun_count
`ifdef RENDER_STATS_EN
    , input max_busy_cycles
`endif
  );

  modport slave (
    input  line_render_start, line_idx, sprites_enabled, layer0_enabled, layer1_enabled,
           sprite_done, layer0_done, layer1_done, err_clear,
    output render_line_idx, sprite_start, layer0_start, layer1_start, render_abort,
           vram_owner, lb_wr_bank, lb_rd_bank, busy, overrun, timeout_err, overrun_count
`ifdef RENDER_STATS_EN
    , output max_busy_cycles
`endif
  );
endinterface

// File: rtl/line_render_scheduler.sv
// Per-line renderer sequencer: bank swap, SPR->L0->L1 VRAM grants, watchdog and overrun tracking.
// Optional feature macro RENDER_STATS_EN adds the max_busy_cycles statistic.
module line_render_scheduler #(
  parameter int TIMEOUT_CYCLES = 1600
) (
  input logic                    clk,
  input logic                    rst_n,
  line_render_scheduler_if.slave bus
);
  localparam int WD_W = $clog2(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {IDLE, SPR, L0, L1, ABORT} state_t;

  state_t          state_q, state_d;
  state_t          resume_q, resume_d;  // where ABORT continues from; IDLE means restart the line
  logic [WD_W-1:0] wd_q, wd_d;
  logic            bank_q;
  logic [8:0]      idx_q;
  logic            spr_start_q, l0_start_q, l1_start_q, abort_q;
  logic            overrun_q, timeout_q;
  logic [7:0]      ovr_cnt_q;
  logic            ovr_evt, to_evt, done_act, renderer, terminal;

  function automatic state_t next_after(input state_t s, input logic en_s, en_0, en_1);
    state_t n;
    n = IDLE;
    case (s)
      IDLE:    n = en_s ? SPR : en_0 ? L0 : en_1 ? L1 : IDLE;
      SPR:     n = en_0 ? L0 : en_1 ? L1 : IDLE;
      L0:      n = en_1 ? L1 : IDLE;
      default: n = IDLE;
    endcase
    return n;
  endfunction

  always_comb begin
    // NOTE: every signal gets a default before any branch so no latch can be inferred.
    state_d  = state_q;
    resume_d = resume_q;
    ovr_evt  = 1'b0;
    to_evt   = 1'b0;
    done_act = 1'b0;
    renderer = state_q inside {SPR, L0, L1};
    case (state_q)
      SPR:     done_act = bus.sprite_done;
      L0:      done_act = bus.layer0_done;
      L1:      done_act = bus.layer1_done;
      default: done_act = 1'b0;
    endcase
    terminal = renderer && (wd_q == WD_W'(TIMEOUT_CYCLES - 1));

    if (bus.line_render_start && state_q != IDLE) begin
      ovr_evt  = 1'b1;
      state_d  = ABORT;
      resume_d = IDLE;
    end else begin
      case (state_q)
        IDLE: if (bus.line_render_start)
          state_d = next_after(IDLE, bus.sprites_enabled, bus.layer0_enabled, bus.layer1_enabled);
        SPR, L0, L1: begin
          if (done_act) begin
            state_d = next_after(state_q, bus.sprites_enabled, bus.layer0_enabled, bus.layer1_enabled);
          end else if (terminal) begin
            to_evt   = 1'b1;
            state_d  = ABORT;
            resume_d = state_q;
          end
        end
        ABORT:   state_d = next_after(resume_q, bus.sprites_enabled, bus.layer0_enabled, bus.layer1_enabled);
        default: state_d = IDLE;
      endcase
    end

    // Staying in the same renderer keeps counting; any transition clears the watchdog.
    wd_d = '0;
    if (renderer && state_d == state_q) wd_d = wd_q + WD_W'(1);
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
    if (!rst_n) begin
      state_q     <= IDLE;
      resume_q    <= IDLE;
      wd_q        <= '0;
      bank_q      <= 1'b0;
      idx_q       <= '0;
      spr_start_q <= 1'b0;
      l0_start_q  <= 1'b0;
      l1_start_q  <= 1'b0;
      abort_q     <= 1'b0;
      overrun_q   <= 1'b0;
      timeout_q   <= 1'b0;
      ovr_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      resume_q    <= resume_d;
      wd_q        <= wd_d;
      spr_start_q <= (state_d == SPR) && (state_q != SPR);
      l0_start_q  <= (state_d == L0) && (state_q != L0);
      l1_start_q  <= (state_d == L1) && (state_q != L1);
      abort_q     <= ovr_evt || to_evt;
      if (bus.line_render_start) begin
        bank_q <= ~bank_q;
        idx_q  <= bus.line_idx;
      end
      // A setting event in the clear cycle wins over the clear.
      if (bus.err_clear) begin
        overrun_q <= ovr_evt;
        timeout_q <= to_evt;
        ovr_cnt_q <= {7'd0, ovr_evt};
      end else begin
        if (ovr_evt) begin
          overrun_q <= 1'b1;
          if (ovr_cnt_q != 8'hFF) ovr_cnt_q <= ovr_cnt_q + 8'd1;
        end
        if (to_evt) timeout_q <= 1'b1;
      end
    end
  end

  assign bus.render_line_idx = idx_q;
  assign bus.sprite_start    = spr_start_q;
  assign bus.layer0_start    = l0_start_q;
  assign bus.layer1_start    = l1_start_q;
  assign bus.render_abort    = abort_q;
  assign bus.vram_owner      = (state_q == SPR) ? 2'd1 :
                               (state_q == L0)  ? 2'd2 :
                               (state_q == L1)  ? 2'd3 : 2'd0;
  assign bus.lb_wr_bank      = bank_q;
  assign bus.lb_rd_bank      = ~bank_q;
  assign bus.busy            = (state_q != IDLE);
  assign bus.overrun         = overrun_q;
  assign bus.timeout_err     = timeout_q;
  assign bus.overrun_count   = ovr_cnt_q;

`ifdef RENDER_STATS_EN
  logic [15:0] seq_cnt_q, max_q, seq_len;
  logic        tainted_q;

  assign seq_len = (seq_cnt_q == 16'hFFFF) ? 16'hFFFF : seq_cnt_q + 16'd1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      seq_cnt_q <= '0;
      max_q     <= '0;
      tainted_q <= 1'b0;
    end else begin
      if (state_q == IDLE) begin
        seq_cnt_q <= '0;
        tainted_q <= 1'b0;
      end else begin
        seq_cnt_q <= seq_len;
        if (ovr_evt) tainted_q <= 1'b1;
      end
      // Overrun-aborted sequences never reach this update because tainted_q is already set.
      if (bus.err_clear) max_q <= '0;
      else if (state_q != IDLE && state_d == IDLE && !tainted_q && seq_len > max_q) max_q <= seq_len;
    end
  end

  assign bus.max_busy_cycles = max_q;
`endif
endmodule

// File: tb/tb_line_render_scheduler.sv
// Directed self-checking bench for line_render_scheduler (default and TIMEOUT_CYCLES=8 instances).
module tb_line_render_scheduler;
  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  line_render_scheduler_if ifa ();
  line_render_scheduler_if ifb ();

  // The short-timeout instance sees the same stimulus; it is only checked in the watchdog scenario.
  assign ifb.line_render_start = ifa.line_render_start;
  assign ifb.line_idx          = ifa.line_idx;
  assign ifb.sprites_enabled   = ifa.sprites_enabled;
  assign ifb.layer0_enabled    = ifa.layer0_enabled;
  assign ifb.layer1_enabled    = ifa.layer1_enabled;
  assign ifb.sprite_done       = ifa.sprite_done;
  assign ifb.layer0_done       = ifa.layer0_done;
  assign ifb.layer1_done       = ifa.layer1_done;
  assign ifb.err_clear         = ifa.err_clear;

  line_render_scheduler u_dut (.clk(clk), .rst_n(rst_n), .bus(ifa));
  line_render_scheduler #(.TIMEOUT_CYCLES(8)) u_dut8 (.clk(clk), .rst_n(rst_n), .bus(ifb));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic set_en(input logic s, input logic l0, input logic l1);
    ifa.sprites_enabled = s;
    ifa.layer0_enabled  = l0;
    ifa.layer1_enabled  = l1;
  endtask

  task automatic pulse_start(input logic [8:0] idx);
    ifa.line_render_start = 1'b1;
    ifa.line_idx          = idx;
    step();
    ifa.line_render_start = 1'b0;
    ifa.line_idx          = '0;
  endtask

  // All renderers enabled, each done 10 cycles after its start; expects a freshly reset DUT.
  task automatic full_line(input string p);
    set_en(1'b1, 1'b1, 1'b1);
    pulse_start(9'd37);                                          // cycle N+1
    check({p, "_spr_start"}, ifa.sprite_start, 1);
    check({p, "_owner_spr"}, ifa.vram_owner, 1);
    check({p, "_busy"}, ifa.busy, 1);
    check({p, "_line_idx"}, ifa.render_line_idx, 37);
    check({p, "_wr_bank"}, ifa.lb_wr_bank, 1);
    check({p, "_rd_bank"}, ifa.lb_rd_bank, 0);
    step();                                                      // N+2
    check({p, "_spr_start_once"}, ifa.sprite_start, 0);
    repeat (9) step();                                           // N+11
    ifa.sprite_done = 1'b1; step(); ifa.sprite_done = 1'b0;      // N+12
    check({p, "_l0_start"}, ifa.layer0_start, 1);
    check({p, "_owner_l0"}, ifa.vram_owner, 2);
    step();                                                      // N+13
    ifa.sprite_done = 1'b1; ifa.layer1_done = 1'b1; step();      // N+14
    ifa.sprite_done = 1'b0; ifa.layer1_done = 1'b0;
    check({p, "_foreign_done_ignored"}, ifa.vram_owner, 2);
    repeat (8) step();                                           // N+22
    ifa.layer0_done = 1'b1; step(); ifa.layer0_done = 1'b0;      // N+23
    check({p, "_l1_start"}, ifa.layer1_start, 1);
    check({p, "_owner_l1"}, ifa.vram_owner, 3);
    repeat (10) step();                                          // N+33
    check({p, "_busy_before_end"}, ifa.busy, 1);
    ifa.layer1_done = 1'b1; step(); ifa.layer1_done = 1'b0;      // N+34
    check({p, "_busy_fall"}, ifa.busy, 0);
    check({p, "_owner_idle"}, ifa.vram_owner, 0);
  endtask

  initial begin
    rst_n                 = 1'b0;
    ifa.line_render_start = 1'b0;
    ifa.line_idx          = '0;
    ifa.sprite_done       = 1'b0;
    ifa.layer0_done       = 1'b0;
    ifa.layer1_done       = 1'b0;
    ifa.err_clear         = 1'b0;
    set_en(1'b1, 1'b1, 1'b1);

    do_reset();
    check("rst_busy", ifa.busy, 0);
    check("rst_owner", ifa.vram_owner, 0);
    check("rst_wr_bank", ifa.lb_wr_bank, 0);
    check("rst_rd_bank", ifa.lb_rd_bank, 1);
    check("rst_line_idx", ifa.render_line_idx, 0);
    check("rst_overrun", ifa.overrun, 0);
    check("rst_count", ifa.overrun_count, 0);
    check("rst_abort", ifa.render_abort, 0);

    full_line("s1");

    // Only layer 0 enabled.
    set_en(1'b0, 1'b1, 1'b0);
    pulse_start(9'd5);
    check("s2_l0_start", ifa.layer0_start, 1);
    check("s2_no_spr_start", ifa.sprite_start, 0);
    check("s2_owner", ifa.vram_owner, 2);
    check("s2_wr_bank", ifa.lb_wr_bank, 0);
    repeat (3) step();
    ifa.layer0_done = 1'b1; step(); ifa.layer0_done = 1'b0;
    check("s2_owner_idle", ifa.vram_owner, 0);
    check("s2_busy_fall", ifa.busy, 0);
    check("s2_no_l1_start", ifa.layer1_start, 0);

    // Nothing enabled: banks swap, scheduler stays idle.
    set_en(1'b0, 1'b0, 1'b0);
    pulse_start(9'd6);
    check("s3_busy", ifa.busy, 0);
    check("s3_wr_bank", ifa.lb_wr_bank, 1);
    check("s3_line_idx", ifa.render_line_idx, 6);

    // Watchdog on the TIMEOUT_CYCLES=8 instance.
    do_reset();
    set_en(1'b1, 1'b1, 1'b1);
    pulse_start(9'd1);
    ifa.sprite_done = 1'b1; step(); ifa.sprite_done = 1'b0;      // S (layer0 start)
    check("wd_l0_start", ifb.layer0_start, 1);
    repeat (7) step();                                           // S+7, terminal cycle
    check("wd_no_early_abort", ifb.render_abort, 0);
    step();                                                      // S+8
    check("wd_abort", ifb.render_abort, 1);
    check("wd_timeout_err", ifb.timeout_err, 1);
    check("wd_abort_owner", ifb.vram_owner, 0);
    step();                                                      // S+9
    check("wd_l1_start", ifb.layer1_start, 1);
    check("wd_abort_once", ifb.render_abort, 0);
    repeat (7) step();                                           // terminal cycle of L1
    ifa.layer1_done = 1'b1; step(); ifa.layer1_done = 1'b0;
    check("wd_done_wins", ifb.render_abort, 0);
    check("wd_done_idle", ifb.busy, 0);
    ifa.err_clear = 1'b1; step(); ifa.err_clear = 1'b0;
    check("wd_err_clear", ifb.timeout_err, 0);

    // Overrun five cycles into SPR.
    do_reset();
    set_en(1'b1, 1'b1, 1'b1);
    pulse_start(9'd10);
    repeat (4) step();
    pulse_start(9'd11);
    check("ov_abort", ifa.render_abort, 1);
    check("ov_owner", ifa.vram_owner, 0);
    check("ov_flag", ifa.overrun, 1);
    check("ov_count", ifa.overrun_count, 1);
    check("ov_wr_bank", ifa.lb_wr_bank, 0);
    check("ov_line_idx", ifa.render_line_idx, 11);
    check("ov_busy", ifa.busy, 1);
    step();
    check("ov_restart_spr", ifa.sprite_start, 1);
    check("ov_abort_once", ifa.render_abort, 0);

    // Overrun outranks a done in the same cycle.
    ifa.sprite_done = 1'b1; pulse_start(9'd12); ifa.sprite_done = 1'b0;
    check("ov_beats_done_abort", ifa.render_abort, 1);
    check("ov_beats_done_owner", ifa.vram_owner, 0);
    check("ov_beats_done_count", ifa.overrun_count, 2);

    // 300 back-to-back overruns saturate the counter.
    ifa.line_render_start = 1'b1;
    repeat (300) step();
    ifa.line_render_start = 1'b0;
    check("sat_count", ifa.overrun_count, 255);
    step();
    ifa.err_clear = 1'b1; step(); ifa.err_clear = 1'b0;
    check("clr_count", ifa.overrun_count, 0);
    check("clr_flag", ifa.overrun, 0);
    ifa.err_clear = 1'b1; pulse_start(9'd13); ifa.err_clear = 1'b0;
    check("clr_vs_set_flag", ifa.overrun, 1);
    check("clr_vs_set_count", ifa.overrun_count, 1);

    // Reset while layer 1 is active.
    step();
    ifa.sprite_done = 1'b1; step(); ifa.sprite_done = 1'b0;
    ifa.layer0_done = 1'b1; step(); ifa.layer0_done = 1'b0;
    check("mid_owner_l1", ifa.vram_owner, 3);
    rst_n = 1'b0; step(); rst_n = 1'b1;
    check("mid_rst_busy", ifa.busy, 0);
    check("mid_rst_owner", ifa.vram_owner, 0);
    check("mid_rst_abort", ifa.render_abort, 0);
    check("mid_rst_overrun", ifa.overrun, 0);
    check("mid_rst_count", ifa.overrun_count, 0);
    check("mid_rst_wr_bank", ifa.lb_wr_bank, 0);
    check("mid_rst_line_idx", ifa.render_line_idx, 0);
    step();
    check("mid_rst_no_late_abort", ifa.render_abort, 0);
    full_line("s6");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/line_render_scheduler.md
Name: line_render_scheduler

Overview:
- Sequences the per-line renderers (sprite, layer 0, layer 1) that fill the line buffers the composer reads.
- On each line_render_start from the composer it swaps the ping-pong line-buffer banks, latches the line index and starts each enabled renderer in turn, granting it the shared VRAM fetch port.
- Enforces a per-renderer watchdog and flags line overruns.

Parameters:
- TIMEOUT_CYCLES, 1600: maximum cycles a renderer may hold the VRAM port before forced abort. Min 2. Watchdog counter width is $clog2(TIMEOUT_CYCLES).

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous reset, active low
- line_render_start  in  1  one-cycle pulse from composer: render next line
- line_idx  in  9  scaled line index from composer, valid with line_render_start
- sprites_enabled  in  1  sprite renderer enable
- layer0_enabled  in  1  layer 0 renderer enable
- layer1_enabled  in  1  layer 1 renderer enable
- sprite_done  in  1  pulse: sprite renderer finished
- layer0_done  in  1  pulse: layer 0 renderer finished
- layer1_done  in  1  pulse: layer 1 renderer finished
- err_clear  in  1  pulse: clear sticky error flags and overrun_count
- render_line_idx  out  9  latched line index for renderers
- sprite_start  out  1  start pulse to sprite renderer
- layer0_start  out  1  start pulse to layer 0 renderer
- layer1_start  out  1  start pulse to layer 1 renderer
- render_abort  out  1  pulse: active renderer must stop immediately
- vram_owner  out  2  VRAM port grant: 0 none, 1 sprite, 2 layer0, 3 layer1
- lb_wr_bank  out  1  line-buffer bank renderers write
- lb_rd_bank  out  1  line-buffer bank composer reads; always ~lb_wr_bank
- busy  out  1  sequence in progress
- overrun  out  1  sticky: line_render_start arrived while busy
- timeout_err  out  1  sticky: watchdog abort occurred
- overrun_count  out  8  saturating overrun counter

Behaviour:
- Reset (rst_n low at clk edge):
  - State IDLE.
  - All pulse outputs 0; vram_owner=0; lb_wr_bank=0; render_line_idx=0; busy=0; overrun=0; timeout_err=0; overrun_count=0; watchdog=0.
  - Reset mid-sequence abandons the sequence with no render_abort pulse.
- States: IDLE, SPR, L0, L1, ABORT. Fixed order SPR -> L0 -> L1.
- "Next enabled" means the first state after the current one in the fixed order whose enable is high, sampled in the transition cycle. If none is enabled, the next state is IDLE.
- Start in IDLE:
  - line_render_start sampled high in cycle N.
  - Cycle N+1: lb_wr_bank toggled, render_line_idx=line_idx from cycle N, state = first enabled.
  - In that state: matching *_start=1 for exactly that cycle, vram_owner = state code, busy=1, watchdog=0.
  - If no renderer is enabled: banks still toggle, state stays IDLE, busy stays 0.
- In SPR/L0/L1:
  - Matching *_done high -> next cycle enters next enabled state, with its start pulse and the watchdog cleared, or IDLE (vram_owner=0, busy=0).
  - Done pulses from non-active renderers are ignored.
- Watchdog:
  - Increments each cycle in SPR/L0/L1.
  - When it equals TIMEOUT_CYCLES-1 with no done that cycle: next cycle render_abort=1, timeout_err<=1, then advance as if done.
  - A done in the terminal cycle wins; no abort is issued.
- Overrun:
  - line_render_start while busy (any non-IDLE state) -> next cycle:
    - state ABORT, render_abort=1, vram_owner=0;
    - overrun<=1, overrun_count+1 (saturates at 255);
    - lb_wr_bank toggled, render_line_idx latched.
  - The following cycle leaves ABORT for the first enabled state (start pulse) or IDLE.
  - Overrun outranks done and watchdog in the same cycle. Only one render_abort is issued.
- line_render_start during ABORT: counts as an overrun and re-latches line_idx; banks toggle again; the state stays ABORT for one more cycle.
- err_clear clears overrun, timeout_err and overrun_count next cycle. A setting event in the same cycle wins: flag set, counter = 1.
- Enables changing mid-sequence affect only transitions, never the currently active renderer.

Optional Feature:
- RENDER_STATS_EN
  - Defined: adds output max_busy_cycles [15:0] (reset 0). It counts cycles from the busy rise to the busy fall for each completed sequence (saturating at 16'hFFFF) and holds the maximum seen. Cleared by err_clear. Overrun-aborted sequences are excluded.
  - Undefined: port absent, no counter logic.

Test Plan:
- All enabled, start with line_idx=9'd37; each done 10 cycles after its start -> sprite_start, layer0_start, layer1_start at N+1, N+12, N+23; render_line_idx=37; lb_wr_bank 0->1; busy falls at N+34.
- sprites_enabled=0, layer1_enabled=0, start -> only layer0_start at N+1, vram_owner=2; layer0_done -> vram_owner=0, busy=0 next cycle.
- TIMEOUT_CYCLES=8, layer0 never done -> render_abort 8 cycles after layer0_start, timeout_err=1, layer1_start next cycle.
- Second line_render_start 5 cycles into SPR -> render_abort next cycle, overrun=1, overrun_count=1, banks toggle twice total, sprite_start the cycle after ABORT.
- 300 back-to-back overruns -> overrun_count=255; err_clear alone -> 0; err_clear coincident with an overrun -> overrun=1, count=1.
- rst_n low during L1 for one cycle -> all outputs at reset values, no render_abort; a new start behaves as the first scenario.
